// File: rtl/ps2_pkg.sv
// Shared scan-code constants, move direction encoding and parser states
// for the PS/2 move scheduler.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10
    } dir_e;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_EXT,
        PS_BRK,
        PS_EXT_BRK
    } parse_state_e;

    // Key vectors are indexed by direction: bit0 up, bit1 left, bit2 right.
    function automatic logic [2:0] decode_key(input logic [7:0] code, input logic ext);
        logic [2:0] hit;
        hit = 3'b000;
        if (ext) begin
            case (code)
                SC_UP:    hit = 3'b001;
                SC_LEFT:  hit = 3'b010;
                SC_RIGHT: hit = 3'b100;
                default:  hit = 3'b000;
            endcase
        end else begin
            case (code)
                SC_W:    hit = 3'b001;
                SC_A:    hit = 3'b010;
                SC_D:    hit = 3'b100;
                default: hit = 3'b000;
            endcase
        end
        return hit;
    endfunction

    function automatic logic [2:0] dir_mask(input dir_e d);
        return 3'b001 << d;
    endfunction

endpackage

// File: rtl/ps2_scan_parser.sv
// Set-2 scan-code parser: tracks E0/F0 prefixes, abandons stale prefixes,
// keeps the held-key vector and flags press edges combinationally.
module ps2_scan_parser
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 2500000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [2:0] held_o,
    output logic [2:0] press_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    parse_state_e  state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    held_q, held_d;
    logic          doMake, doBreak, useExt;
    logic [2:0]    keyHit;

    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        doMake  = 1'b0;
        doBreak = 1'b0;
        useExt  = 1'b0;
        if (rx_valid_i) begin
            // Repeated prefixes leave the state untouched.
            unique case (state_q)
                PS_IDLE: begin
                    if (rx_data_i == SC_EXT)      state_d = PS_EXT;
                    else if (rx_data_i == SC_BRK) state_d = PS_BRK;
                    else                          doMake = 1'b1;
                end
                PS_EXT: begin
                    if (rx_data_i == SC_BRK) begin
                        state_d = PS_EXT_BRK;
                    end else if (rx_data_i != SC_EXT) begin
                        doMake  = 1'b1;
                        useExt  = 1'b1;
                        state_d = PS_IDLE;
                    end
                end
                PS_BRK: begin
                    if (rx_data_i != SC_BRK) begin
                        doBreak = 1'b1;
                        state_d = PS_IDLE;
                    end
                end
                PS_EXT_BRK: begin
                    if (rx_data_i != SC_BRK) begin
                        doBreak = 1'b1;
                        useExt  = 1'b1;
                        state_d = PS_IDLE;
                    end
                end
                default: state_d = PS_IDLE;
            endcase
        end else if (state_q != PS_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) state_d = PS_IDLE;
            else                               tmo_d   = tmo_q + TW'(1);
        end

        keyHit  = decode_key(rx_data_i, useExt);
        press_o = doMake ? (keyHit & ~held_q) : 3'b000;
        held_d  = held_q;
        if (doMake)  held_d = held_q | keyHit;
        if (doBreak) held_d = held_q & ~keyHit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PS_IDLE;
            tmo_q   <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            held_q  <= held_d;
        end
    end

    assign held_o = held_q;

endmodule

// File: rtl/ps2_move_scheduler.sv
// Turns held keys into press and auto-repeat move requests and arbitrates
// them onto one valid/ready command port (up first, left/right round-robin).
module ps2_move_scheduler
    import ps2_pkg::*;
#(
    parameter int unsigned REPEAT_CYC  = 5000000,
    parameter int unsigned TIMEOUT_CYC = 2500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       held_up,
    output logic       held_left,
    output logic       held_right,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready
);

    localparam int RW = $clog2(REPEAT_CYC);

    logic [2:0]    held, press, repFire, grantMask, avail;
    logic          transfer;
    logic [RW-1:0] rep_q [3];
    logic [RW-1:0] rep_d [3];
    logic [2:0]    pend_q, pend_d;
    logic          move_valid_q, move_valid_d;
    dir_e          move_dir_q, move_dir_d;
    dir_e          rr_q, rr_d;

    ps2_scan_parser #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_parser (
        .clk_i      (CLOCK_50),
        .rst_ni     (reset),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .held_o     (held),
        .press_o    (press)
    );

    always_comb begin
        rep_d   = rep_q;
        repFire = 3'b000;
        for (int d = 0; d < 3; d++) begin
            if (!held[d] || press[d]) begin
                rep_d[d] = '0;
            end else if (rep_q[d] == RW'(REPEAT_CYC - 1)) begin
                rep_d[d]   = '0;
                repFire[d] = 1'b1;
            end else begin
                rep_d[d] = rep_q[d] + RW'(1);
            end
        end
    end

    // The bit on offer stays pending until it transfers, so new requests coalesce.
    always_comb begin
        transfer     = move_valid_q && move_ready;
        grantMask    = transfer ? dir_mask(move_dir_q) : 3'b000;
        avail        = pend_q & ~grantMask;
        pend_d       = avail | press | repFire;
        move_valid_d = move_valid_q;
        move_dir_d   = move_dir_q;
        rr_d         = rr_q;
        if (transfer && move_dir_q == DIR_LEFT)  rr_d = DIR_RIGHT;
        if (transfer && move_dir_q == DIR_RIGHT) rr_d = DIR_LEFT;
        if (!move_valid_q || transfer) begin
            move_valid_d = |avail;
            if (avail[0])                 move_dir_d = DIR_UP;
            else if (avail[1] && avail[2]) move_dir_d = rr_q;
            else if (avail[1])            move_dir_d = DIR_LEFT;
            else if (avail[2])            move_dir_d = DIR_RIGHT;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            rep_q        <= '{default: '0};
            pend_q       <= '0;
            move_valid_q <= 1'b0;
            move_dir_q   <= DIR_UP;
            rr_q         <= DIR_LEFT;
        end else begin
            rep_q        <= rep_d;
            pend_q       <= pend_d;
            move_valid_q <= move_valid_d;
            move_dir_q   <= move_dir_d;
            rr_q         <= rr_d;
        end
    end

    assign held_up    = held[0];
    assign held_left  = held[1];
    assign held_right = held[2];
    assign move_valid = move_valid_q;
    assign move_dir   = move_dir_q;

endmodule

// File: tb/tb_ps2_move_scheduler.sv
// Self-checking bench for ps2_move_scheduler: directed scenarios with literal
// expectations plus randomized byte streams checked against a timing model.
module tb_ps2_move_scheduler;

    localparam int REP = 8;
    localparam int TMO = 16;

    logic       clock;
    logic       reset;
    logic [7:0] rxData;
    logic       rxValid;
    logic       heldUp, heldLeft, heldRight;
    logic       moveValid;
    logic [1:0] moveDir;
    logic       moveReady;

    int checks = 0;
    int errors = 0;

    // Model state: prefix flags, idle counter, held keys with press times,
    // pending requests and the command on offer.
    bit mExt, mBrk;
    int mIdle;
    bit mHeld [3];
    int mPressT [3];
    bit mPend [3];
    bit mMv;
    int mMd;
    int mRr;
    int cyc;

    int grantLog [$];

    logic [7:0] codeTable [9] = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h74, 8'h1D, 8'h1C, 8'h23, 8'h29};
    logic [7:0] rndByte;
    bit         rndValid, rndReady;

    ps2_move_scheduler #(
        .REPEAT_CYC  (REP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .CLOCK_50   (clock),
        .reset      (reset),
        .rx_data    (rxData),
        .rx_valid   (rxValid),
        .held_up    (heldUp),
        .held_left  (heldLeft),
        .held_right (heldRight),
        .move_valid (moveValid),
        .move_dir   (moveDir),
        .move_ready (moveReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int keyOf(input logic [7:0] b, input bit ext);
        if (ext) begin
            if (b == 8'h75) return 0;
            if (b == 8'h6B) return 1;
            if (b == 8'h74) return 2;
        end else begin
            if (b == 8'h1D) return 0;
            if (b == 8'h1C) return 1;
            if (b == 8'h23) return 2;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mExt = 0; mBrk = 0; mIdle = 0;
        for (int k = 0; k < 3; k++) begin
            mHeld[k] = 0; mPend[k] = 0; mPressT[k] = 0;
        end
        mMv = 0; mMd = 0; mRr = 1;
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic modelEdge(input bit v, input logic [7:0] b, input bit rdy);
        int  g, k, oldRr;
        bit  setM [3];
        bit  av [3];
        cyc++;
        g = (mMv && rdy) ? mMd : -1;
        for (int d = 0; d < 3; d++)
            setM[d] = mHeld[d] && (cyc > mPressT[d]) && ((cyc - mPressT[d]) % REP == 0);
        k = -1;
        if (v) begin
            mIdle = 0;
            if (!mExt && !mBrk) begin
                if (b == 8'hE0)      mExt = 1;
                else if (b == 8'hF0) mBrk = 1;
                else begin
                    k = keyOf(b, 0);
                    if (k >= 0 && !mHeld[k]) begin
                        mHeld[k] = 1; setM[k] = 1; mPressT[k] = cyc;
                    end
                end
            end else if (!mBrk) begin
                if (b == 8'hF0) mBrk = 1;
                else if (b != 8'hE0) begin
                    k = keyOf(b, 1);
                    if (k >= 0 && !mHeld[k]) begin
                        mHeld[k] = 1; setM[k] = 1; mPressT[k] = cyc;
                    end
                    mExt = 0;
                end
            end else if (b != 8'hF0) begin
                k = keyOf(b, mExt);
                if (k >= 0) mHeld[k] = 0;
                mExt = 0; mBrk = 0;
            end
        end else if (mExt || mBrk) begin
            mIdle++;
            if (mIdle >= TMO) begin
                mExt = 0; mBrk = 0; mIdle = 0;
            end
        end

        oldRr = mRr;
        if (g == 1) mRr = 2;
        if (g == 2) mRr = 1;
        for (int d = 0; d < 3; d++) begin
            av[d]    = mPend[d] && (d != g);
            mPend[d] = av[d] || setM[d];
        end
        if (!mMv || g >= 0) begin
            mMv = 1;
            if (av[0])              mMd = 0;
            else if (av[1] && av[2]) mMd = oldRr;
            else if (av[1])         mMd = 1;
            else if (av[2])         mMd = 2;
            else                    mMv = 0;
        end
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkOutput();
        checkVal("held", int'({heldRight, heldLeft, heldUp}),
                 int'({mHeld[2], mHeld[1], mHeld[0]}));
        checkVal("move_valid", int'(moveValid), int'(mMv));
        if (mMv) checkVal("move_dir", int'(moveDir), mMd);
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] b, input bit rdy);
        rxValid   = v;
        rxData    = b;
        moveReady = rdy;
        if (moveValid && rdy) grantLog.push_back(int'(moveDir));
        @(posedge clock);
        modelEdge(v, b, rdy);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, rdy);
    endtask

    initial begin
        cyc = 0;
        modelReset();
        reset = 1'b0; rxValid = 1'b0; rxData = 8'h00; moveReady = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkVal("reset held", int'({heldRight, heldLeft, heldUp}), 0);
        checkVal("reset move_valid", int'(moveValid), 0);
        checkVal("reset move_dir", int'(moveDir), 0);
        #2 reset = 1'b1;
        idle(2, 1);

        $display("[TB] extended up press");
        grantLog.delete();
        applyStimulus(1, 8'hE0, 1);
        applyStimulus(1, 8'h75, 1);
        checkVal("t1 held_up", int'(heldUp), 1);
        checkVal("t1 valid latency", int'(moveValid), 0);
        applyStimulus(0, 8'h00, 1);
        checkVal("t1 valid", int'(moveValid), 1);
        checkVal("t1 dir", int'(moveDir), 0);
        applyStimulus(0, 8'h00, 1);
        checkVal("t1 valid drop", int'(moveValid), 0);
        applyStimulus(1, 8'hE0, 1);
        applyStimulus(1, 8'hF0, 1);
        applyStimulus(1, 8'h75, 1);
        checkVal("t1 release", int'(heldUp), 0);
        idle(4, 1);
        checkVal("t1 grant count", grantLog.size(), 1);

        $display("[TB] left press and release while stalled");
        grantLog.delete();
        applyStimulus(1, 8'hE0, 0);
        applyStimulus(1, 8'h6B, 0);
        checkVal("t2 held_left", int'(heldLeft), 1);
        idle(10, 0);
        checkVal("t2 offered dir", int'(moveDir), 1);
        applyStimulus(1, 8'hE0, 0);
        applyStimulus(1, 8'hF0, 0);
        applyStimulus(1, 8'h6B, 0);
        checkVal("t2 held_left off", int'(heldLeft), 0);
        checkVal("t2 still offered", int'(moveValid), 1);
        idle(5, 1);
        checkVal("t2 grant count", grantLog.size(), 1);
        if (grantLog.size() > 0) checkVal("t2 grant dir", grantLog[0], 1);

        $display("[TB] A and D held with auto-repeat");
        grantLog.delete();
        applyStimulus(1, 8'h1C, 1);
        applyStimulus(1, 8'h23, 1);
        idle(40, 1);
        checkVal("t3 enough grants", int'(grantLog.size() >= 8), 1);
        if (grantLog.size() > 0) checkVal("t3 first left", grantLog[0], 1);
        for (int i = 1; i < grantLog.size(); i++)
            checkVal("t3 alternate", int'(grantLog[i] != grantLog[i-1]), 1);
        applyStimulus(1, 8'hF0, 1);
        applyStimulus(1, 8'h1C, 1);
        applyStimulus(1, 8'hF0, 1);
        applyStimulus(1, 8'h23, 1);
        idle(12, 1);

        $display("[TB] up priority under backpressure");
        applyStimulus(1, 8'hE0, 0);
        applyStimulus(1, 8'h75, 0);
        applyStimulus(1, 8'h1C, 0);
        checkVal("t4 valid", int'(moveValid), 1);
        checkVal("t4 dir up", int'(moveDir), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 8'h00, 0);
            checkVal("t4 stable dir", int'(moveDir), 0);
        end
        applyStimulus(0, 8'h00, 1);
        checkVal("t4 then left", int'(moveDir), 1);
        checkVal("t4 then valid", int'(moveValid), 1);
        applyStimulus(1, 8'hE0, 1);
        applyStimulus(1, 8'hF0, 1);
        applyStimulus(1, 8'h75, 1);
        applyStimulus(1, 8'hF0, 1);
        applyStimulus(1, 8'h1C, 1);
        idle(12, 1);

        $display("[TB] prefix timeout");
        applyStimulus(1, 8'hE0, 1);
        idle(TMO + 2, 1);
        applyStimulus(1, 8'h75, 1);
        checkVal("t5 held_up", int'(heldUp), 0);
        idle(3, 1);

        $display("[TB] reset mid-sequence");
        applyStimulus(1, 8'hE0, 0);
        applyStimulus(1, 8'h75, 0);
        applyStimulus(0, 8'h00, 0);
        checkVal("t6 valid before", int'(moveValid), 1);
        applyStimulus(1, 8'hE0, 0);
        applyStimulus(1, 8'hF0, 0);
        reset = 1'b0;
        #2;
        modelReset();
        checkVal("t6 reset valid", int'(moveValid), 0);
        checkVal("t6 reset held", int'({heldRight, heldLeft, heldUp}), 0);
        reset = 1'b1;
        applyStimulus(1, 8'hE0, 1);
        applyStimulus(1, 8'h74, 1);
        checkVal("t6 held_right", int'(heldRight), 1);
        applyStimulus(0, 8'h00, 1);
        checkVal("t6 right valid", int'(moveValid), 1);
        checkVal("t6 right dir", int'(moveDir), 2);
        applyStimulus(1, 8'hE0, 1);
        applyStimulus(1, 8'hF0, 1);
        applyStimulus(1, 8'h74, 1);
        idle(6, 1);

        $display("[TB] randomized stream");
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                idle(TMO + int'($urandom_range(0, 4)), $urandom_range(0, 1) == 1);
            end
            rndValid = ($urandom_range(0, 99) < 35);
            rndByte  = codeTable[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) rndByte = 8'($urandom_range(0, 255));
            rndReady = ($urandom_range(0, 3) != 0);
            applyStimulus(rndValid, rndValid ? rndByte : 8'h00, rndReady);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_move_scheduler.md
Name: ps2_move_scheduler

Overview:
Sits between PS2_Controller (received_data / received_data_en byte stream) and the game logic. Parses PS/2 set-2 scan-code sequences (E0 extended prefix, F0 break prefix) into held-key state for up/left/right. Generates move requests on press and on auto-repeat while a key is held. Arbitrates pending requests onto a single valid/ready move-command interface.

Parameters:
REPEAT_CYC, 5000000, cycles between auto-repeat requests while a key is held (100 ms @ 50 MHz); must be >= 2
TIMEOUT_CYC, 2500000, idle cycles after which a partial prefix sequence is abandoned (50 ms)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset (one clock domain; polarity and synchronicity fixed)
rx_data  input  8  scan-code byte from PS2_Controller
rx_valid  input  1  single-cycle strobe qualifying rx_data
held_up  output  1  up key (E0 75 or W 1D) currently held
held_left  output  1  left key (E0 6B or A 1C) currently held
held_right  output  1  right key (E0 74 or D 23) currently held
move_valid  output  1  a move command is offered
move_dir  output  2  00=up, 01=left, 10=right; 11 never driven
move_ready  input  1  consumer accepts; transfer when move_valid && move_ready

Behaviour:
- Reset (reset=0, async): parser IDLE; held_* = 0; pending = 000; repeat and timeout counters = 0; move_valid = 0; move_dir = 00; round-robin pointer = LEFT.
- Parser FSM is advanced only on rx_valid.
  - IDLE: E0 -> EXT; F0 -> BRK; otherwise decode as make, non-extended.
  - EXT: F0 -> EXT_BRK; otherwise decode as make, extended; return to IDLE.
  - BRK: decode as break, non-extended; return to IDLE.
  - EXT_BRK: decode as break, extended; return to IDLE.
  - E0 received in EXT, or F0 received in BRK/EXT_BRK: stay in the current state (tolerate duplicates).
- Decode:
  - Unrecognised codes are ignored but still complete the sequence.
  - Extended codes map to arrows only. Non-extended 1D/1C/23 map to W/A/D aliases. Both the arrow and its alias drive the same held bit.
- Make: sets held bit. If the bit was 0 (press edge), set that direction's pending bit and clear its repeat counter. Typematic repeats (make while already held) have no effect.
- Break: clears held bit. Pending bit is NOT cleared, so a press+release shorter than the grant latency still yields exactly one move.
- Timeout: in EXT/BRK/EXT_BRK, count cycles without rx_valid. On reaching TIMEOUT_CYC, return to IDLE with no decode. Counter clears on every rx_valid and while in IDLE.
- Auto-repeat: one counter per direction, runs while held. On reaching REPEAT_CYC-1, set pending and wrap to 0. Counter clears when not held.
- Pending bits coalesce: at most one outstanding request per direction. If a set and a grant of the same direction occur in the same cycle, the bit stays 1.
- Arbitration (output register):
  - When move_valid=0 or a transfer occurs this cycle, select the next command from pending, excluding the bit being granted this cycle.
  - Up has fixed highest priority. Left/right are round-robin; the pointer advances past the granted one.
  - move_valid/move_dir are registered: 1-cycle latency from pending set to move_valid.
  - move_dir is stable while move_valid=1 && move_ready=0.
  - move_valid may be 1 every cycle under back-to-back ready.
- Release of a key while its command is being offered does not withdraw it.
- held_* update the cycle after the completing rx_valid (registered).

Decomposition:
- Shared package ps2_pkg:
  - scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_UP=75, SC_LEFT=6B, SC_RIGHT=74, SC_W=1D, SC_A=1C, SC_D=23
  - move_dir encoding DIR_UP/DIR_LEFT/DIR_RIGHT
  - parser state enum
- One sub-module: ps2_scan_parser (FSM + timeout + held bits, outputs press-edge pulses and held vector).
- Repeat counters and arbiter stay in the top.

Test Plan:
- Stimulus: bytes E0,75 with move_ready=1.
  Response: held_up=1; exactly one move_valid with dir 00 one cycle after pending set.
- Stimulus: E0,6B then E0,F0,6B 10 cycles later.
  Response: held_left rises, then falls; one left command only, even with move_ready held 0 until after the break.
- Stimulus: hold 1C (A) and 23 (D) simultaneously with REPEAT_CYC=8, move_ready=1.
  Response: left/right commands alternate L,R,L,R; no direction is granted twice consecutively.
- Stimulus: up and left pending, move_ready=0 for 5 cycles.
  Response: move_dir=00 stable throughout; after ready, up is granted, then left.
- Stimulus: E0 then silence for TIMEOUT_CYC (set 16).
  Response: parser returns to IDLE; a following 75 is decoded as non-extended and ignored, so held_up stays 0.
- Stimulus: assert reset low mid-sequence (after E0,F0) with move_valid=1.
  Response: move_valid=0 and held_*=0 immediately; next E0,74 produces held_right=1 normally.
